kernel_invoke_scheduler: RTL and testbench
==========================================

Name: kernel_invoke_scheduler

Overview:
Shares one HLS kernel with an ap_ctrl_chain block-level handshake (ap_start/ap_ready/ap_done/ap_continue/ap_idle) among N_REQ requesters. A round-robin arbiter grants one requester at a time and sequences one kernel invocation per grant. It returns a one-cycle ack to the owner and records invocation latency and count for the same statistics that the sim-side module and loop monitors collect. Sits between the testbench or host-side requesters and the kernel top.

Parameters:
N_REQ, 4, number of requesters (2..16)
CNT_W, 32, width of the latency and invocation counters
SEL_W, $clog2(N_REQ), width of the owner index (derived, not overridable)

Ports:
ap_clk        in   1      clock; all logic on its rising edge
ap_rst_n      in   1      asynchronous active-low reset
req           in   N_REQ  level requests; bit i held high until ack[i]
ack           out  N_REQ  one-cycle pulse to the owner when its invocation completes
busy          out  1      high in every state except IDLE
sel           out  SEL_W  index of the current or most recent owner
ap_start      out  1      kernel start
ap_ready      in   1      kernel accepted inputs
ap_done       in   1      kernel finished
ap_idle       in   1      kernel idle
ap_continue   out  1      kernel continue
last_latency  out  CNT_W  latency of the last completed invocation, in cycles
invoke_count  out  CNT_W  number of completed invocations

Behaviour:
- Reset (async assert, sync release): state=IDLE; ack, busy, sel, ap_start, last_latency, invoke_count = 0; internal last-grant pointer = N_REQ-1, so the first grant goes to req[0].
- FSM states: IDLE, START, WAIT_DONE, RESP.
- IDLE
  - Transition requires |req=1 and ap_idle=1.
  - Grant the first set bit searching from (last+1) mod N_REQ upward, with wrap.
  - Register sel and clear the latency counter; next state is START.
  - With ap_idle=0, stay in IDLE regardless of req.
- START
  - ap_start=1 (registered, asserted in the cycle START is entered). Latency counter increments every cycle.
  - ap_ready=1: ap_start drops the next cycle.
  - ap_done=1 in the same cycle: go to RESP; otherwise go to WAIT_DONE.
  - ap_ready=0: stay in START with ap_start held.
- WAIT_DONE: ap_start=0; counter increments; on ap_done=1, go to RESP.
- ap_continue is combinational: ap_done & (state==START | state==WAIT_DONE). It is therefore high exactly in the cycle ap_done is accepted, and 0 otherwise.
- RESP (1 cycle)
  - ack[sel]=1 (registered pulse, one cycle); all other ack bits stay 0.
  - last_latency = counter value = cycles from the first ap_start cycle through the ap_done cycle inclusive, minimum 1.
  - invoke_count += 1, wrapping at 2^CNT_W.
  - last pointer = sel; next state is IDLE. req is ignored in this cycle; the earliest next grant is the cycle after RESP.
- Latency counter saturates at 2^CNT_W-1 and does not wrap.
- req changes after grant are ignored until ack; a deasserted request bit in IDLE is simply not granted.
- A request from the owner that stays high after ack is treated as a new request at lowest round-robin priority.
- ap_done outside START/WAIT_DONE is ignored: no ack, no continue.
- ap_rst_n asserted mid-invocation aborts immediately to reset values; no ack is issued for the aborted invocation.
- sel holds its value in IDLE (last owner).

Test Plan:
- Single request: req=4'b0001, kernel ready in cycle 1 and done 5 cycles after start → ap_start high 1 cycle, ap_continue pulses with ap_done, ack=4'b0001 for 1 cycle, last_latency=6, invoke_count=1.
- Round robin: req=4'b1111 held and re-raised after each ack → grants in order 0,1,2,3,0; invoke_count=5; busy drops for exactly 1 IDLE cycle between invocations.
- Ready stall: ap_ready held low 3 cycles → ap_start held 4 cycles, drops the cycle after ap_ready; latency includes the stall cycles.
- Same-cycle ready+done: ap_ready=ap_done=1 on the first start cycle → WAIT_DONE skipped, last_latency=1, ack next cycle.
- ap_idle=0 with req=4'b0100 → no ap_start until ap_idle=1, then sel=2.
- Reset mid-WAIT_DONE, then spurious ap_done with ap_rst_n low → all outputs 0, no ack, ap_continue=0; after release, req=4'b1000 is granted with sel=3, the pointer having been reset so the search starts at 0.

Source files
------------

// File: rtl/kernel_invoke_scheduler.sv
// kernel_invoke_scheduler
//
// Shares one HLS kernel that uses the ap_ctrl_chain block-level handshake
// among N_REQ requesters. A round-robin arbiter picks one requester. The block
// then runs one kernel invocation for that owner (start, ready, done,
// continue) and pulses ack to the owner when the invocation completes. It also
// records the latency of the last invocation and a running invocation count.
//
// Ports:
//   ap_clk        clock, all logic on its rising edge
//   ap_rst_n      asynchronous active-low reset
//   req           level requests, bit i held high until ack[i]
//   ack           one-cycle completion pulse to the owner
//   busy          high whenever the scheduler is not idle
//   sel           index of the current or most recent owner
//   ap_start      kernel start (registered)
//   ap_ready      kernel accepted its inputs
//   ap_done       kernel finished
//   ap_idle       kernel idle, required before a new grant
//   ap_continue   kernel continue, high in the cycle ap_done is accepted
//   last_latency  cycles from first ap_start cycle through ap_done cycle
//   invoke_count  number of completed invocations (wraps)

module kernel_invoke_scheduler #(
  parameter  int N_REQ = 4,
  parameter  int CNT_W = 32,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic [SEL_W-1:0] sel,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             ap_continue,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] invoke_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   lat_q, lat_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               ap_start_q, ap_start_d;
  logic [CNT_W-1:0]   last_latency_q, last_latency_d;
  logic [CNT_W-1:0]   invoke_count_q, invoke_count_d;

  logic [CNT_W-1:0]   lat_inc;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;

  // The latency counter saturates rather than wrapping, so a hung kernel
  // reads as "very long" instead of a misleading small number.
  assign lat_inc = (&lat_q) ? lat_q : lat_q + CNT_W'(1);

  // Round-robin search: start one past the last owner and wrap, so the
  // previous owner ends up with the lowest priority.
  always_comb begin : arbiter
    int               cand;
    logic [SEL_W-1:0] cand_idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last_q) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = SEL_W'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // State and datapath registers. Reset puts the last-grant pointer on the
  // highest index so the first search begins at requester 0.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      last_q         <= SEL_W'(N_REQ - 1);
      lat_q          <= '0;
      ack_q          <= '0;
      ap_start_q     <= 1'b0;
      last_latency_q <= '0;
      invoke_count_q <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      last_q         <= last_d;
      lat_q          <= lat_d;
      ack_q          <= ack_d;
      ap_start_q     <= ap_start_d;
      last_latency_q <= last_latency_d;
      invoke_count_q <= invoke_count_d;
    end
  end

  // Next-state logic. A grant needs both a pending request and an idle
  // kernel. Once the kernel has taken its inputs, a done in that same cycle
  // skips WAIT_DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld && ap_idle) begin
          state_d = START;
        end
      end
      START: begin
        if (ap_ready) begin
          state_d = ap_done ? RESP : WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ap_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath updates. ack, last_latency and invoke_count are all
  // loaded on the way into RESP, so all three are visible during RESP.
  // ap_start is registered from the next state, so it rises in the first
  // START cycle and falls in the cycle after ap_ready.
  always_comb begin
    sel_d          = sel_q;
    last_d         = last_q;
    lat_d          = lat_q;
    ack_d          = '0;
    ap_start_d     = (state_d == START);
    last_latency_d = last_latency_q;
    invoke_count_d = invoke_count_q;
    unique case (state_q)
      IDLE: begin
        if (state_d == START) begin
          sel_d = grant_idx;
          lat_d = '0;
        end
      end
      START, WAIT_DONE: begin
        lat_d = lat_inc;
        if (state_d == RESP) begin
          last_latency_d = lat_inc;
          invoke_count_d = invoke_count_q + CNT_W'(1);
          ack_d          = N_REQ'(1) << sel_q;
          last_d         = sel_q;
        end
      end
      default: begin
      end
    endcase
  end

  assign ack          = ack_q;
  assign busy         = (state_q != IDLE);
  assign sel          = sel_q;
  assign ap_start     = ap_start_q;
  assign ap_continue  = ap_done && ((state_q == START) || (state_q == WAIT_DONE));
  assign last_latency = last_latency_q;
  assign invoke_count = invoke_count_q;

endmodule

// File: tb/tb_kernel_invoke_scheduler.sv
// Testbench for kernel_invoke_scheduler: scenario tasks plus a randomized
// run, checked against a reference model that tracks the expected owner,
// the invocation count and the expected latency of each invocation.

module tb_kernel_invoke_scheduler;

  localparam int N     = 4;
  localparam int CNT_W = 32;
  localparam int SEL_W = $clog2(N);

  logic             ap_clk;
  logic             ap_rst_n;
  logic [N-1:0]     req;
  logic [N-1:0]     ack;
  logic             busy;
  logic [SEL_W-1:0] sel;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_continue;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] invoke_count;

  int n_checks;
  int n_fail;
  int mdl_last;
  int mdl_count;

  kernel_invoke_scheduler #(.N_REQ(N), .CNT_W(CNT_W)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .req          (req),
    .ack          (ack),
    .busy         (busy),
    .sel          (sel),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_continue  (ap_continue),
    .last_latency (last_latency),
    .invoke_count (invoke_count)
  );

  // 10 ns clock
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Round-robin rule: first set request searching upward from last+1, wrapping
  function automatic int next_grant(input int last, input logic [N-1:0] r);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    ap_rst_n = 1'b0;
    req = '0; ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    step();
    step();
    ap_rst_n = 1'b1;
    mdl_last = N - 1;
    mdl_count = 0;
    step();
  endtask

  // Act as the kernel for one invocation. ready_at and done_at count cycles
  // from the first ap_start cycle (0). The model expects a latency of done_at+1.
  task automatic do_invoke(input int exp_owner, input int ready_at, input int done_at,
                           input bit rereq, output int waits);
    logic [N-1:0] exp_ack;
    waits = 0;
    do begin
      step();
      waits++;
    end while (!ap_start && waits < 50);
    n_checks++;
    if (!ap_start) begin
      n_fail++;
      $display("[TB] FAIL start_timeout: ap_start=%b after %0d cycles, required 1", ap_start, waits);
      return;
    end
    n_checks++;
    if (sel !== SEL_W'(exp_owner)) begin
      n_fail++;
      $display("[TB] FAIL grant_sel: got %0d required %0d", sel, exp_owner);
    end
    for (int c = 0; c <= done_at; c++) begin
      ap_ready = (c == ready_at);
      ap_done  = (c == done_at);
      #1;
      n_checks++;
      if (ap_start !== (c <= ready_at)) begin
        n_fail++;
        $display("[TB] FAIL ap_start_c%0d: got %b required %b", c, ap_start, (c <= ready_at));
      end
      n_checks++;
      if (ap_continue !== (c == done_at)) begin
        n_fail++;
        $display("[TB] FAIL ap_continue_c%0d: got %b required %b", c, ap_continue, (c == done_at));
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL busy_run: got %b required 1", busy);
      end
      step();
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    exp_ack = '0;
    exp_ack[exp_owner] = 1'b1;
    n_checks++;
    if (ack !== exp_ack) begin
      n_fail++;
      $display("[TB] FAIL resp_ack: got %b required %b", ack, exp_ack);
    end
    n_checks++;
    if (last_latency !== CNT_W'(done_at + 1)) begin
      n_fail++;
      $display("[TB] FAIL last_latency: got %0d required %0d", last_latency, done_at + 1);
    end
    n_checks++;
    if (invoke_count !== CNT_W'(mdl_count + 1)) begin
      n_fail++;
      $display("[TB] FAIL invoke_count: got %0d required %0d", invoke_count, mdl_count + 1);
    end
    mdl_count++;
    mdl_last = exp_owner;
    if (!rereq) req[exp_owner] = 1'b0;
    step();
    n_checks++;
    if (ack !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_resp_idle: ack=%b busy=%b required ack=0000 busy=0", ack, busy);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    req = 4'b1111; ap_ready = 1'b0; ap_done = 1'b1; ap_idle = 1'b1;
    step();
    step();
    n_checks++;
    if (ack !== '0 || busy !== 1'b0 || sel !== '0 || ap_start !== 1'b0 ||
        last_latency !== '0 || invoke_count !== '0 || ap_continue !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: ack=%b busy=%b sel=%0d start=%b lat=%0d cnt=%0d cont=%b required all 0",
               ack, busy, sel, ap_start, last_latency, invoke_count, ap_continue);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int w;
    req = 4'b0001;
    do_invoke(0, 0, 5, 1'b0, w);
  endtask

  task automatic test_round_robin();
    int w;
    int order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      do_invoke(order[k], 0, 2, 1'b1, w);
      if (k > 0) begin
        n_checks++;
        if (w !== 1) begin
          n_fail++;
          $display("[TB] FAIL rr_idle_gap_%0d: got %0d idle cycles required 1", k, w);
        end
      end
    end
    req = '0;
    n_checks++;
    if (invoke_count !== CNT_W'(5)) begin
      n_fail++;
      $display("[TB] FAIL rr_count: got %0d required 5", invoke_count);
    end
  endtask

  task automatic test_ready_stall();
    int w;
    req = 4'b0010;
    do_invoke(next_grant(mdl_last, req), 3, 5, 1'b0, w);
  endtask

  task automatic test_same_cycle();
    int w;
    req = 4'b0100;
    do_invoke(next_grant(mdl_last, req), 0, 0, 1'b0, w);
  endtask

  task automatic test_idle_block();
    int w;
    ap_idle = 1'b0;
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (ap_start !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL idle_block_%0d: ap_start=%b busy=%b required 0 0", k, ap_start, busy);
      end
    end
    ap_idle = 1'b1;
    do_invoke(2, 1, 3, 1'b0, w);
  endtask

  task automatic test_spurious_done();
    req = '0;
    ap_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (ap_continue !== 1'b0 || ack !== '0 || invoke_count !== CNT_W'(mdl_count)) begin
        n_fail++;
        $display("[TB] FAIL spurious_done_%0d: cont=%b ack=%b cnt=%0d required 0 0000 %0d",
                 k, ap_continue, ack, invoke_count, mdl_count);
      end
      step();
    end
    ap_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    req = 4'b0001;
    w = 0;
    do begin
      step();
      w++;
    end while (!ap_start && w < 50);
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    step();
    ap_rst_n = 1'b0;
    #1;
    n_checks++;
    if (ack !== '0 || busy !== 1'b0 || sel !== '0 || ap_start !== 1'b0 ||
        last_latency !== '0 || invoke_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_values: ack=%b busy=%b sel=%0d start=%b lat=%0d cnt=%0d required all 0",
               ack, busy, sel, ap_start, last_latency, invoke_count);
    end
    ap_done = 1'b1;
    #1;
    n_checks++;
    if (ap_continue !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_continue: got %b required 0", ap_continue);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (ack !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_hold_%0d: ack=%b busy=%b required 0000 0", k, ack, busy);
      end
    end
    ap_done = 1'b0;
    req = 4'b1000;
    ap_rst_n = 1'b1;
    mdl_last = N - 1;
    mdl_count = 0;
    do_invoke(3, 0, 2, 1'b0, w);
  endtask

  task automatic test_random();
    int w, owner, ra, da;
    logic [N-1:0] r;
    for (int k = 0; k < 24; k++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      req = req | r;
      owner = next_grant(mdl_last, req);
      ra = $urandom_range(0, 3);
      da = ra + $urandom_range(0, 4);
      do_invoke(owner, ra, da, 1'($urandom_range(0, 1)), w);
      n_checks++;
      if (w !== 1) begin
        n_fail++;
        $display("[TB] FAIL rand_gap_%0d: got %0d idle cycles required 1", k, w);
      end
    end
    req = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mdl_last = N - 1;
    mdl_count = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_ready_stall();
    test_same_cycle();
    test_idle_block();
    test_spurious_done();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
